// File: rtl/pipe_core_pkg.sv
// pipe_core_pkg: opcodes, instruction field positions and the decoded ID bundle
// shared by the pipelined core (forwarding option: PIPE_FWD_EN).
package pipe_core_pkg;
   typedef enum logic [1:0] {
      OP_ADD   = 2'b00,
      OP_SUB   = 2'b01,
      OP_LOAD  = 2'b10,
      OP_STORE = 2'b11
   } op_t;

   localparam int OP_LSB  = 14;
   localparam int RS1_LSB = 10;
   localparam int RS2_LSB = 6;
   localparam int RD_LSB  = 2;

   typedef struct packed {
      logic       valid;
      op_t        op;
      logic [3:0] rs1;
      logic [3:0] rs2;
      logic [3:0] rd;
   } dec_t;

   function automatic dec_t decode(input logic v, input logic [15:0] instr);
      return '{valid: v, op: op_t'(instr[OP_LSB +: 2]), rs1: instr[RS1_LSB +: 4],
               rs2: instr[RS2_LSB +: 4], rd: instr[RD_LSB +: 4]};
   endfunction
endpackage

// File: rtl/pipe_regfile.sv
// pipe_regfile: 16 x DATA_W, 2 read / 1 write, r0 reads zero, same-cycle write-through.
module pipe_regfile #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic [3:0]        ra1,
   input  logic [3:0]        ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   input  logic              we,
   input  logic [3:0]        wa,
   input  logic [DATA_W-1:0] wd
);
   logic [DATA_W-1:0] mem [16];

   always_ff @(posedge clk)
      if (we && wa != 4'd0) mem[wa] <= wd;

   assign rd1 = (ra1 == 4'd0) ? '0 : (we && wa == ra1) ? wd : mem[ra1];
   assign rd2 = (ra2 == 4'd0) ? '0 : (we && wa == ra2) ? wd : mem[ra2];
endmodule

// File: rtl/pipelined_core_fwd.sv
// pipelined_core_fwd: 4-stage IF/ID/EX/WB integer core with external memories.
// Define PIPE_FWD_EN for WB->EX bypass; otherwise distance-1 RAW hazards interlock.
module pipelined_core_fwd
   import pipe_core_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int PC_W    = 8,
   parameter int DADDR_W = 8,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               reset,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [15:0]        imem_rdata,
   input  logic               imem_valid,
   output logic [DADDR_W-1:0] dmem_addr,
   output logic               dmem_re,
   input  logic [DATA_W-1:0]  dmem_rdata,
   output logic               dmem_we,
   output logic [DATA_W-1:0]  dmem_wdata,
   output logic               retire_valid,
   output logic [3:0]         retire_rd,
   output logic [DATA_W-1:0]  retire_data,
   output logic [CNT_W-1:0]   retire_cnt,
   output logic               stall
);
   typedef struct packed {
      dec_t              d;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } idex_t;

   typedef struct packed {
      logic              valid;
      op_t               op;
      logic [3:0]        rd;
      logic [DATA_W-1:0] res;
   } exwb_t;

   logic [PC_W-1:0]   pc;
   logic              if_valid;
   logic [15:0]       if_instr;
   dec_t              id;
   idex_t             ex;
   exwb_t             wb;
   logic [DATA_W-1:0] rf_a, rf_b, a, b, sum, ex_res, wb_data;
   logic              wb_we;

   assign imem_addr = pc;
   assign id        = decode(if_valid, if_instr);
   assign wb_we     = wb.valid && wb.op != OP_STORE && wb.rd != 4'd0;
   assign wb_data   = (wb.op == OP_LOAD) ? dmem_rdata : wb.res;

   pipe_regfile #(.DATA_W(DATA_W)) u_rf (
      .clk (clk),
      .ra1 (id.rs1),
      .ra2 (id.rs2),
      .rd1 (rf_a),
      .rd2 (rf_b),
      .we  (wb_we),
      .wa  (wb.rd),
      .wd  (wb_data)
   );

`ifdef PIPE_FWD_EN
   assign a     = (wb_we && wb.rd == ex.d.rs1) ? wb_data : ex.a;
   assign b     = (wb_we && wb.rd == ex.d.rs2) ? wb_data : ex.b;
   assign stall = 1'b0;
`else
   // Distance-2 dependencies are already covered by regfile write-through.
   assign a     = ex.a;
   assign b     = ex.b;
   assign stall = id.valid && ex.d.valid && ex.d.op != OP_STORE && ex.d.rd != 4'd0 &&
                  (id.rs1 == ex.d.rd || id.rs2 == ex.d.rd);
`endif

   // STORE carries its data down to WB so the retire port can report it.
   assign sum          = a + b;
   assign ex_res       = (ex.d.op == OP_SUB) ? a - b : (ex.d.op == OP_STORE) ? b : sum;
   assign dmem_addr    = (ex.d.op == OP_STORE) ? a[DADDR_W-1:0] : sum[DADDR_W-1:0];
   assign dmem_re      = ex.d.valid && ex.d.op == OP_LOAD;
   assign dmem_we      = ex.d.valid && ex.d.op == OP_STORE;
   assign dmem_wdata   = b;
   assign retire_valid = wb.valid;
   assign retire_rd    = (wb.op == OP_STORE) ? 4'd0 : wb.rd;
   assign retire_data  = wb_data;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         pc         <= '0;
         if_valid   <= 1'b0;
         if_instr   <= '0;
         ex         <= '0;
         wb         <= '0;
         retire_cnt <= '0;
      end else begin
         if (!stall) begin
            if_valid <= imem_valid;
            if (imem_valid) begin
               if_instr <= imem_rdata;
               pc       <= pc + PC_W'(1);
            end
         end
         if (id.valid && !stall) ex <= '{d: id, a: rf_a, b: rf_b};
         else ex <= '0;
         wb         <= '{valid: ex.d.valid, op: ex.d.op, rd: ex.d.rd, res: ex_res};
         retire_cnt <= retire_cnt + CNT_W'(ex.d.valid);
      end
endmodule

// File: tb/tb_pipelined_core_fwd.sv
// tb_pipelined_core_fwd: directed programs with hand-computed retire expectations,
// latency/stall accounting and a behavioural data memory.
module tb_pipelined_core_fwd;
   localparam logic [1:0] ADD = 2'd0, SUB = 2'd1, LD = 2'd2, ST = 2'd3;
`ifdef PIPE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  imem_addr;
   logic [15:0] imem_rdata;
   logic        imem_valid;
   logic [7:0]  dmem_addr;
   logic        dmem_re;
   logic [15:0] dmem_rdata = '0;
   logic        dmem_we;
   logic [15:0] dmem_wdata;
   logic        retire_valid;
   logic [3:0]  retire_rd;
   logic [15:0] retire_data;
   logic [31:0] retire_cnt;
   logic        stall;

   pipelined_core_fwd dut (
      .clk          (clk),
      .reset        (reset),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .imem_valid   (imem_valid),
      .dmem_addr    (dmem_addr),
      .dmem_re      (dmem_re),
      .dmem_rdata   (dmem_rdata),
      .dmem_we      (dmem_we),
      .dmem_wdata   (dmem_wdata),
      .retire_valid (retire_valid),
      .retire_rd    (retire_rd),
      .retire_data  (retire_data),
      .retire_cnt   (retire_cnt),
      .stall        (stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  rd;
      logic [15:0] d;
   } ret_t;

   logic [15:0] prog [256];
   logic [15:0] dmem [256];
   ret_t        exp_q[$];
   int          acc_q[$];
   int          n_checks = 0, n_err = 0, cyc = 0, n_ret = 0, n_stall = 0, n_wr = 0;
   logic [7:0]  wr_addr = '0;
   logic [15:0] wr_data = '0;

   assign imem_rdata = prog[imem_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] enc(input logic [1:0] op, input logic [3:0] s1, s2, d);
      return {op, s1, s2, d, 2'b00};
   endfunction

   task automatic push(input logic [3:0] rd, input logic [15:0] d);
      exp_q.push_back('{rd: rd, d: d});
   endtask

   // Called just after a rising edge; leaves imem_valid low after n acceptances.
   task automatic run(input int n);
      int acc = 0;
      int guard = 0;
      imem_valid = 1'b1;
      while (acc < n && guard < 2000) begin
         @(negedge clk);
         if (imem_valid && !stall) acc++;
         guard++;
      end
      check("accepted", acc, n);
      @(posedge clk);
      #1 imem_valid = 1'b0;
   endtask

   task automatic drain();
      repeat (8) @(negedge clk);
      check("drain pending", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) begin
      cyc <= cyc + 1;
      dmem_rdata <= dmem_re ? dmem[dmem_addr] : '0;
      if (dmem_we) begin
         dmem[dmem_addr] <= dmem_wdata;
         n_wr    <= n_wr + 1;
         wr_addr <= dmem_addr;
         wr_data <= dmem_wdata;
      end
   end

   // Retire latency is 3 plus any stall cycles spent in ID by that instruction.
   always @(negedge clk)
      if (!reset) begin
         if (stall) begin
            n_stall++;
            if (acc_q.size() > 0) acc_q[acc_q.size()-1] += 1;
         end
         if (imem_valid && !stall) acc_q.push_back(cyc);
         if (retire_valid) begin
            check("expected retire", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               ret_t e;
               int   a;
               e = exp_q.pop_front();
               a = (acc_q.size() > 0) ? acc_q.pop_front() : -100;
               n_ret++;
               check("retire_rd", retire_rd, e.rd);
               check("retire_data", retire_data, e.d);
               check("latency", cyc - a, 3);
               check("retire_cnt", retire_cnt, n_ret);
            end
         end
      end

   initial begin
      for (int i = 0; i < 256; i++) dmem[i] <= '0;
      dmem[0]  <= 16'd5;
      dmem[5]  <= 16'd7;
      dmem[9]  <= 16'd1;
      dmem[10] <= 16'd4;
      dmem[12] <= 16'hBEEF;
   end

   initial begin
      int s, w;
      reset = 1'b1;
      imem_valid = 1'b0;
      for (int i = 0; i < 256; i++) prog[i] = enc(ADD, 0, 0, 0);
      prog[0]  = enc(LD, 0, 0, 1);
      prog[1]  = enc(LD, 1, 0, 2);
      prog[2]  = enc(ADD, 1, 2, 3);
      prog[3]  = enc(SUB, 3, 1, 4);
      prog[4]  = enc(LD, 1, 1, 9);
      prog[5]  = enc(LD, 2, 1, 10);
      prog[6]  = enc(ST, 9, 10, 0);
      prog[7]  = enc(LD, 9, 0, 5);
      prog[8]  = enc(ADD, 5, 5, 6);
      prog[9]  = enc(LD, 9, 1, 11);
      prog[10] = enc(SUB, 0, 11, 7);
      prog[11] = enc(ADD, 11, 11, 0);
      prog[12] = enc(ADD, 0, 1, 12);
      prog[13] = enc(ADD, 1, 2, 13);
      prog[14] = enc(ADD, 13, 1, 14);
      repeat (2) @(negedge clk);
      check("rst imem_addr", imem_addr, 0);
      check("rst retire_valid", retire_valid, 0);
      check("rst retire_cnt", retire_cnt, 0);
      check("rst dmem_we", dmem_we, 0);
      check("rst dmem_re", dmem_re, 0);
      check("rst stall", stall, 0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      s = n_stall;
      push(1, 16'd5); push(2, 16'd7);
      run(2); drain();
      check("stalls load-use", n_stall - s, FWD ? 0 : 1);
      s = n_stall;
      push(3, 16'd12); push(4, 16'd7);
      run(2); drain();
      check("stalls add-sub", n_stall - s, FWD ? 0 : 1);
      s = n_stall;
      w = n_wr;
      push(9, 16'd4); push(10, 16'hBEEF); push(0, 16'hBEEF); push(5, 16'hBEEF); push(6, 16'h7DDE);
      run(5); drain();
      check("stalls store-load", n_stall - s, FWD ? 0 : 2);
      check("store count", n_wr - w, 1);
      check("store addr", wr_addr, 4);
      check("store data", wr_data, 16'hBEEF);
      check("dmem[4]", dmem[4], 16'hBEEF);
      s = n_stall;
      push(11, 16'd1); push(7, 16'hFFFF); push(0, 16'd2); push(12, 16'd5);
      run(4); drain();
      check("stalls wrap/r0", n_stall - s, FWD ? 0 : 1);
      s = n_stall;
      push(13, 16'd12); push(14, 16'd17);
      run(1);
      repeat (3) begin
         @(negedge clk);
         check("pc hold", imem_addr, 14);
      end
      @(posedge clk);
      #1;
      run(1); drain();
      check("stalls gap", n_stall - s, 0);
      for (int i = 15; i < 256; i++) push(0, 16'd0);
      run(241);
      @(negedge clk);
      check("pc wrap", imem_addr, 0);
      drain();
      prog[0] = enc(ST, 9, 1, 0);
      prog[1] = enc(LD, 0, 0, 2);
      w = n_wr;
      run(2);
      check("store in EX", dmem_we, 1);
      reset = 1'b1;
      #1;
      exp_q.delete();
      acc_q.delete();
      n_ret = 0;
      check("mid-rst dmem_we", dmem_we, 0);
      check("mid-rst dmem_re", dmem_re, 0);
      check("mid-rst dmem_addr", dmem_addr, 0);
      check("mid-rst dmem_wdata", dmem_wdata, 0);
      check("mid-rst imem_addr", imem_addr, 0);
      check("mid-rst retire_valid", retire_valid, 0);
      check("mid-rst retire_rd", retire_rd, 0);
      check("mid-rst retire_data", retire_data, 0);
      check("mid-rst retire_cnt", retire_cnt, 0);
      check("mid-rst stall", stall, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("no write after rst", n_wr - w, 0);
      check("dmem[4] kept", dmem[4], 16'hBEEF);
      reset = 1'b0;
      prog[0] = enc(LD, 0, 0, 1);
      push(1, 16'd5);
      @(posedge clk);
      #1;
      run(1); drain();
      check("final retire_cnt", retire_cnt, 1);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
